// File: rtl/fault_mem_cfg.sv
// Pipelined single-port memory model with run-time programmable fault injection.
// Optional macro FAULT_CNT_EN builds the saturating corruption counter; otherwise fault_cnt is 0.
module fault_mem_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 16,
  parameter int CNT_WIDTH  = 8,
  localparam int BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  cfg_load,
  input  logic [2:0]            cfg_type,
  input  logic [ADDR_WIDTH-1:0] cfg_vaddr,
  input  logic [BIT_W-1:0]      cfg_bit,
  input  logic [ADDR_WIDTH-1:0] cfg_aaddr,
  output logic [CNT_WIDTH-1:0]  fault_cnt
);

  typedef enum logic [2:0] {
    FT_NONE = 3'd0, FT_SAF0 = 3'd1, FT_SAF1 = 3'd2,
    FT_TFUP = 3'd3, FT_TFDN = 3'd4, FT_CFIN = 3'd5
  } fault_e;

  localparam logic [ADDR_WIDTH:0] CAP_L = (ADDR_WIDTH + 1)'(CAPACITY);

  logic [DATA_WIDTH-1:0] mem [CAPACITY];

  logic                  s1_vld_q, s1_vld_d;
  logic                  s1_wr_q, s1_wr_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic [DATA_WIDTH-1:0] s1_wdata_q, s1_wdata_d;
  logic [DATA_WIDTH-1:0] rd_hold_q, rd_hold_d;
  logic [DATA_WIDTH-1:0] rdata_out_q, rdata_out_d;
  logic [2:0]            cfg_type_q, cfg_type_d;
  logic [ADDR_WIDTH-1:0] cfg_vaddr_q, cfg_vaddr_d;
  logic [BIT_W-1:0]      cfg_bit_q, cfg_bit_d;
  logic [ADDR_WIDTH-1:0] cfg_aaddr_q, cfg_aaddr_d;

  fault_e                eff_type_s;
  logic                  addr_ok_s, vaddr_ok_s, on_vic_s;
  logic                  is_rd_s, mem_we_s, flip_s, hit_s;
  logic                  old_bit_s, new_bit_s;
  logic [DATA_WIDTH-1:0] old_s, vic_word_s, mem_wdata_s, vic_wdata_s, rd_word_s;

  // Effective fault type: reserved codes and a self-coupled CFin act as fault-free.
  always_comb begin
    eff_type_s = FT_NONE;
    case (cfg_type_q)
      3'd1:    eff_type_s = FT_SAF0;
      3'd2:    eff_type_s = FT_SAF1;
      3'd3:    eff_type_s = FT_TFUP;
      3'd4:    eff_type_s = FT_TFDN;
      3'd5:    eff_type_s = (cfg_aaddr_q != cfg_vaddr_q) ? FT_CFIN : FT_NONE;
      default: eff_type_s = FT_NONE;
    endcase
  end

  // Stage-1 array operation with fault rules applied against the current config.
  always_comb begin
    addr_ok_s   = ({1'b0, s1_addr_q} < CAP_L);
    vaddr_ok_s  = ({1'b0, cfg_vaddr_q} < CAP_L);
    old_s       = mem[addr_ok_s ? s1_addr_q : {ADDR_WIDTH{1'b0}}];
    vic_word_s  = mem[vaddr_ok_s ? cfg_vaddr_q : {ADDR_WIDTH{1'b0}}];
    on_vic_s    = addr_ok_s && (s1_addr_q == cfg_vaddr_q);
    old_bit_s   = old_s[cfg_bit_q];
    new_bit_s   = s1_wdata_q[cfg_bit_q];
    is_rd_s     = s1_vld_q && !s1_wr_q;
    mem_we_s    = s1_vld_q && s1_wr_q && addr_ok_s;
    mem_wdata_s = s1_wdata_q;
    rd_word_s   = addr_ok_s ? old_s : {DATA_WIDTH{1'b0}};
    vic_wdata_s = vic_word_s;
    vic_wdata_s[cfg_bit_q] = ~vic_word_s[cfg_bit_q];
    flip_s      = 1'b0;
    hit_s       = 1'b0;
    case (eff_type_s)
      FT_SAF0, FT_SAF1: begin
        // The read override is not a stored corruption, so it never counts.
        if (on_vic_s) begin
          mem_wdata_s[cfg_bit_q] = (eff_type_s == FT_SAF1);
          rd_word_s[cfg_bit_q]   = (eff_type_s == FT_SAF1);
          hit_s = mem_we_s && (new_bit_s != (eff_type_s == FT_SAF1));
        end else begin
          hit_s = 1'b0;
        end
      end
      FT_TFUP: begin
        if (mem_we_s && on_vic_s && !old_bit_s && new_bit_s) begin
          mem_wdata_s[cfg_bit_q] = 1'b0;
          hit_s = 1'b1;
        end else begin
          hit_s = 1'b0;
        end
      end
      FT_TFDN: begin
        if (mem_we_s && on_vic_s && old_bit_s && !new_bit_s) begin
          mem_wdata_s[cfg_bit_q] = 1'b1;
          hit_s = 1'b1;
        end else begin
          hit_s = 1'b0;
        end
      end
      FT_CFIN: begin
        if (mem_we_s && (s1_addr_q == cfg_aaddr_q) && (old_bit_s != new_bit_s) && vaddr_ok_s) begin
          flip_s = 1'b1;
          hit_s  = 1'b1;
        end else begin
          hit_s = 1'b0;
        end
      end
      default: hit_s = 1'b0;
    endcase
  end

  // Next-state for pipeline, read path and config registers.
  always_comb begin
    s1_vld_d    = 1'b1;
    s1_wr_d     = write_read;
    s1_addr_d   = address;
    s1_wdata_d  = wdata;
    rd_hold_d   = is_rd_s ? rd_word_s : rd_hold_q;
    rdata_out_d = rd_hold_q;
    if (cfg_load) begin
      cfg_type_d  = cfg_type;
      cfg_vaddr_d = cfg_vaddr;
      cfg_bit_d   = cfg_bit;
      cfg_aaddr_d = cfg_aaddr;
    end else begin
      cfg_type_d  = cfg_type_q;
      cfg_vaddr_d = cfg_vaddr_q;
      cfg_bit_d   = cfg_bit_q;
      cfg_aaddr_d = cfg_aaddr_q;
    end
  end

  // Control and datapath registers; reset leaves a non-updating read of address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_wr_q     <= 1'b0;
      s1_addr_q   <= {ADDR_WIDTH{1'b0}};
      s1_wdata_q  <= {DATA_WIDTH{1'b0}};
      rd_hold_q   <= {DATA_WIDTH{1'b0}};
      rdata_out_q <= {DATA_WIDTH{1'b0}};
      cfg_type_q  <= 3'd0;
      cfg_vaddr_q <= {ADDR_WIDTH{1'b0}};
      cfg_bit_q   <= {BIT_W{1'b0}};
      cfg_aaddr_q <= {ADDR_WIDTH{1'b0}};
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_wr_q     <= s1_wr_d;
      s1_addr_q   <= s1_addr_d;
      s1_wdata_q  <= s1_wdata_d;
      rd_hold_q   <= rd_hold_d;
      rdata_out_q <= rdata_out_d;
      cfg_type_q  <= cfg_type_d;
      cfg_vaddr_q <= cfg_vaddr_d;
      cfg_bit_q   <= cfg_bit_d;
      cfg_aaddr_q <= cfg_aaddr_d;
    end
  end

  // Storage array: aggressor word and coupled victim bit may both update at one edge.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[s1_addr_q] <= mem_wdata_s;
    end
    if (flip_s) begin
      mem[cfg_vaddr_q] <= vic_wdata_s;
    end
  end

  assign rdata = rdata_out_q;

`ifdef FAULT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Saturating hit counter, cleared whenever a new config is loaded.
  always_comb begin
    if (cfg_load) begin
      cnt_d = {CNT_WIDTH{1'b0}};
    end else if (hit_s && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fault_cnt = cnt_q;
`else
  logic unused_hit_s;
  assign unused_hit_s = hit_s;
  assign fault_cnt    = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_fault_mem_cfg.sv
// Randomised scoreboard bench for fault_mem_cfg against a word-level behavioural model.
module tb_fault_mem_cfg;
  localparam int DW = 8, AW = 4, CAP = 12, CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          write_read = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          cfg_load = 1'b0;
  logic [2:0]    cfg_type = '0;
  logic [AW-1:0] cfg_vaddr = '0;
  logic [2:0]    cfg_bit = '0;
  logic [AW-1:0] cfg_aaddr = '0;
  logic [CW-1:0] fault_cnt;

  fault_mem_cfg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .write_read(write_read), .address(address), .wdata(wdata),
    .rdata(rdata), .cfg_load(cfg_load), .cfg_type(cfg_type), .cfg_vaddr(cfg_vaddr),
    .cfg_bit(cfg_bit), .cfg_aaddr(cfg_aaddr), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_mem [CAP];
  int m_type = 0, m_va = 0, m_bit = 0, m_aa = 0, m_cnt = 0;
  bit pend_v = 0, pend_wr = 0;
  int pend_a = 0;
  logic [DW-1:0] pend_d = '0;
  bit mon_en = 1;
  logic [2:0] rd_pipe;
  logic [DW-1:0] mon_exp;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference: one array operation applied with the configuration in force at its edge.
  task automatic exec(input bit wr, input int a, input logic [DW-1:0] d);
    int t;
    bit hit;
    logic [DW-1:0] v, old, stored;
    t = (m_type > 5) ? 0 : m_type;
    if (t == 5 && m_aa == m_va) t = 0;
    if (a >= CAP) begin
      if (!wr) exp_q.push_back(8'h00);
    end else if (!wr) begin
      v = m_mem[a];
      if (a == m_va && t == 1) v[m_bit] = 1'b0;
      if (a == m_va && t == 2) v[m_bit] = 1'b1;
      exp_q.push_back(v);
    end else begin
      old = m_mem[a];
      stored = d;
      if (a == m_va) begin
        if (t == 1) stored[m_bit] = 1'b0;
        if (t == 2) stored[m_bit] = 1'b1;
        if (t == 3 && old[m_bit] == 1'b0 && d[m_bit] == 1'b1) stored[m_bit] = 1'b0;
        if (t == 4 && old[m_bit] == 1'b1 && d[m_bit] == 1'b0) stored[m_bit] = 1'b1;
      end
      m_mem[a] = stored;
      hit = (stored != d);
      if (t == 5 && a == m_aa && old[m_bit] != d[m_bit] && m_va < CAP) begin
        m_mem[m_va][m_bit] = ~m_mem[m_va][m_bit];
        hit = 1'b1;
      end
      if (hit && m_cnt < 255) m_cnt++;
    end
  endtask

  // One clock cycle of stimulus: called at a falling edge, returns at the next one.
  task automatic step(input bit wr, input int a, input logic [DW-1:0] d,
                      input bit ld, input int ty, input int va, input int b, input int aa);
    int exp_cnt;
    if (pend_v) exec(pend_wr, pend_a, pend_d);
    if (ld) begin
      m_type = ty; m_va = va; m_bit = b; m_aa = aa; m_cnt = 0;
    end
    pend_v = 1; pend_wr = wr; pend_a = a; pend_d = d;
    write_read = wr; address = a[AW-1:0]; wdata = d;
    cfg_load = ld; cfg_type = ty[2:0]; cfg_vaddr = va[AW-1:0]; cfg_bit = b[2:0]; cfg_aaddr = aa[AW-1:0];
    @(posedge clk);
    @(negedge clk);
`ifdef FAULT_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    chk("fault_cnt", int'(fault_cnt), exp_cnt);
  endtask

  task automatic op(input bit wr, input int a, input logic [DW-1:0] d);
    step(wr, a, d, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic cfg(input int ty, input int va, input int b, input int aa);
    step(1'b0, 0, 8'h00, 1'b1, ty, va, b, aa);
  endtask

  // Tracks which sampled operations were reads so the monitor knows when rdata is due.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pipe <= 3'b000;
    else rd_pipe <= {rd_pipe[1:0], ~write_read};
  end

  always @(negedge clk) begin
    if (rst_n && mon_en && rd_pipe[2]) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rdata_unexpected actual=0x%0h expected=none", rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rdata", int'(rdata), int'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("reset_rdata", int'(rdata), 0);
    chk("reset_fault_cnt", int'(fault_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < 16; a++) op(1'b1, a, 8'($urandom));
    op(1'b1, 3, 8'hA5); op(1'b0, 3, 8'h00);
    cfg(3, 5, 4, 0);
    op(1'b1, 5, 8'h00); op(1'b1, 5, 8'hFF); op(1'b0, 5, 8'h00);
    op(1'b1, 5, 8'h10); op(1'b0, 5, 8'h00);
    cfg(2, 2, 0, 0);
    op(1'b1, 2, 8'h00); op(1'b1, 1, 8'h00); op(1'b0, 2, 8'h00); op(1'b0, 1, 8'h00);
    cfg(5, 9, 3, 7);
    op(1'b1, 9, 8'h00); op(1'b1, 7, 8'h00); op(1'b1, 7, 8'h08); op(1'b0, 9, 8'h00);
    op(1'b1, 7, 8'h08); op(1'b0, 9, 8'h00);
    op(1'b1, 13, 8'hFF); op(1'b0, 13, 8'h00); op(1'b0, 11, 8'h00);
    // Victim write executes at the very edge that loads TF-up, so it is stored intact.
    op(1'b1, 6, 8'h00); op(1'b1, 6, 8'hFF); cfg(3, 6, 0, 0); op(1'b0, 6, 8'h00);
    op(1'b1, 6, 8'h00); op(1'b1, 6, 8'hFF); op(1'b0, 6, 8'h00);
    cfg(5, 4, 2, 4);
    op(1'b1, 4, 8'h00); op(1'b1, 4, 8'h04); op(1'b0, 4, 8'h00);
    cfg(6, 4, 2, 4); op(1'b1, 4, 8'h00); op(1'b0, 4, 8'h00);
    cfg(2, 8, 7, 0); op(1'b1, 8, 8'h00); op(1'b1, 0, 8'h3C);

    // Asynchronous reset between edges: outputs clear at once, config returns to fault-free.
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_rdata", int'(rdata), 0);
    chk("midreset_fault_cnt", int'(fault_cnt), 0);
    exp_q.delete();
    pend_v = 0; m_type = 0; m_va = 0; m_bit = 0; m_aa = 0; m_cnt = 0;
    write_read = 1'b0; address = '0; cfg_load = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op(1'b0, 0, 8'h00);
    op(1'b1, 0, 8'h00); op(1'b0, 0, 8'h00); op(1'b0, 3, 8'h00);

    cfg(3, 5, 4, 0);
    for (int i = 0; i < 300; i++) begin
      op(1'b1, 5, 8'h00); op(1'b1, 5, 8'hFF);
    end
    op(1'b0, 5, 8'h00);

    for (int i = 0; i < 500; i++) begin
      int va;
      if ($urandom_range(0, 24) == 0) begin
        va = $urandom_range(0, 13);
        cfg($urandom_range(0, 7), va, $urandom_range(0, 7),
            ($urandom_range(0, 3) == 0) ? va : $urandom_range(0, 13));
      end else begin
        op(1'($urandom_range(0, 1)), $urandom_range(0, 13), 8'($urandom));
      end
    end

    exec(pend_wr, pend_a, pend_d);
    pend_v = 0;
    repeat (2) @(negedge clk);
    #1 mon_en = 0;
    chk("drain_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
